// File: rtl/fpu_mem_arbiter.sv
// fpu_mem_arbiter
//   Shares the single data-memory port between the integer load/store unit
//   (port 0, lsu_*) and the FPU FLW/FSW interface (port 1, fpu_*). One
//   transaction at a time is granted (round robin on ties), driven to memory
//   and held until mem_ready, or aborted with an error after TIMEOUT access
//   cycles. The response is a one-cycle ready pulse, with rdata and err, on
//   the owning port only.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   lsu_re/we/addr/wdata           port 0 request (level, held until ready)
//   lsu_ready/rdata/err            port 0 response (one-cycle pulse)
//   fpu_re/we/addr/wdata           port 1 request
//   fpu_ready/rdata/err            port 1 response
//   mem_addr/wdata/re/we           registered memory request
//   mem_rdata, mem_ready           memory response
//   busy                           high while in ACCESS or RESP
//   grant_id                       port owning the current/last transaction
module fpu_mem_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_re,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_ready,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_err,
  input  logic              fpu_re,
  input  logic              fpu_we,
  input  logic [ADDR_W-1:0] fpu_addr,
  input  logic [31:0]       fpu_wdata,
  output logic              fpu_ready,
  output logic [31:0]       fpu_rdata,
  output logic              fpu_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant_id
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                   state_reg;
  logic                     last_grant_reg;
  logic                     grant_reg;
  logic                     illegal_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic [ADDR_W-1:0]        mem_addr_reg;
  logic [31:0]              mem_wdata_reg;
  logic                     mem_re_reg;
  logic                     mem_we_reg;
  logic [1:0]               ready_reg;
  logic [1:0]               err_reg;
  logic [1:0][31:0]         rdata_reg;

  // Requests gathered into per-port vectors, index = port number.
  logic [1:0]               re_vec;
  logic [1:0]               we_vec;
  logic [1:0]               req_vec;
  logic [1:0][ADDR_W-1:0]   addr_vec;
  logic [1:0][31:0]         wdata_vec;

  assign re_vec    = {fpu_re, lsu_re};
  assign we_vec    = {fpu_we, lsu_we};
  assign addr_vec  = {fpu_addr, lsu_addr};
  assign wdata_vec = {fpu_wdata, lsu_wdata};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_vec[gi] = re_vec[gi] | we_vec[gi];
    end
  endgenerate

  // Arbitration: single requester wins; on a tie the port that did not
  // own the previous transaction wins.
  logic pick_valid;
  logic pick_port;

  always_comb begin
    pick_valid = |req_vec;
    pick_port  = 1'b0;
    if (&req_vec) begin
      pick_port = ~last_grant_reg;
    end else if (req_vec[1]) begin
      pick_port = 1'b1;
    end
  end

  // Access termination. An illegal (re & we) request spends one cycle in
  // ACCESS with the memory strobes low and then ends with an error, so its
  // response lands at the same latency as a zero-wait access.
  logic finish_ok;
  logic finish_err;

  always_comb begin
    finish_ok  = mem_ready & ~illegal_reg;
    finish_err = illegal_reg;
    if (TIMEOUT != 0 && cnt_reg == CNT_LAST && !mem_ready) begin
      finish_err = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      illegal_reg    <= 1'b0;
      cnt_reg        <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_re_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      ready_reg      <= '0;
      err_reg        <= '0;
      rdata_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_reg      <= pick_port;
            last_grant_reg <= pick_port;
            mem_addr_reg   <= addr_vec[pick_port];
            mem_wdata_reg  <= wdata_vec[pick_port];
            cnt_reg        <= '0;
            state_reg      <= ACCESS;
            if (re_vec[pick_port] && we_vec[pick_port]) begin
              illegal_reg <= 1'b1;
              mem_re_reg  <= 1'b0;
              mem_we_reg  <= 1'b0;
            end else begin
              illegal_reg <= 1'b0;
              mem_re_reg  <= re_vec[pick_port];
              mem_we_reg  <= we_vec[pick_port];
            end
          end
        end

        ACCESS: begin
          if (finish_ok || finish_err) begin
            mem_re_reg           <= 1'b0;
            mem_we_reg           <= 1'b0;
            illegal_reg          <= 1'b0;
            ready_reg[grant_reg] <= 1'b1;
            err_reg[grant_reg]   <= finish_err;
            // Write completions and errors return zero data.
            rdata_reg[grant_reg] <= (finish_ok && mem_re_reg) ? mem_rdata : 32'd0;
            state_reg            <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        RESP: begin
          ready_reg <= '0;
          err_reg   <= '0;
          rdata_reg <= '0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_re    = mem_re_reg;
  assign mem_we    = mem_we_reg;
  assign busy      = (state_reg != IDLE);
  assign grant_id  = grant_reg;

  assign lsu_ready = ready_reg[0];
  assign lsu_err   = err_reg[0];
  assign lsu_rdata = rdata_reg[0];
  assign fpu_ready = ready_reg[1];
  assign fpu_err   = err_reg[1];
  assign fpu_rdata = rdata_reg[1];

endmodule

// File: tb/tb_fpu_mem_arbiter.sv
// Testbench for fpu_mem_arbiter (TIMEOUT=4). Expected responses are pushed
// to a scoreboard queue when a request is driven and popped by a monitor
// when a ready pulse appears; directed checks cover memory-side timing.
module tb_fpu_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              rst;
  logic              lsu_re, lsu_we;
  logic [ADDR_W-1:0] lsu_addr;
  logic [31:0]       lsu_wdata;
  logic              lsu_ready;
  logic [31:0]       lsu_rdata;
  logic              lsu_err;
  logic              fpu_re, fpu_we;
  logic [ADDR_W-1:0] fpu_addr;
  logic [31:0]       fpu_wdata;
  logic              fpu_ready;
  logic [31:0]       fpu_rdata;
  logic              fpu_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_re, mem_we;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic              busy;
  logic              grant_id;

  fpu_mem_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .lsu_re(lsu_re), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_ready(lsu_ready), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .fpu_re(fpu_re), .fpu_we(fpu_we), .fpu_addr(fpu_addr), .fpu_wdata(fpu_wdata),
    .fpu_ready(fpu_ready), .fpu_rdata(fpu_rdata), .fpu_err(fpu_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  resp_t sb[$];

  // Memory model: read data is rd_base ^ address; ready after wait_cycles
  // access cycles unless hang is set. stray drives mem_ready while idle.
  localparam logic [31:0] RD_BASE = 32'hDEADBEEF ^ 32'h100;
  int wait_cycles = 0;
  int acc_cnt     = 0;
  bit hang        = 1'b0;
  bit stray       = 1'b0;

  always @(negedge clk) begin
    if (mem_re || mem_we) begin
      if (!hang && acc_cnt == wait_cycles) begin
        mem_ready = 1'b1;
        mem_rdata = RD_BASE ^ mem_addr;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0_0BAD ^ mem_addr;
      end
      acc_cnt++;
    end else begin
      mem_ready = stray;
      mem_rdata = 32'hFFFF_FFFF;
      acc_cnt   = 0;
    end
  end

  // Response monitor
  logic        mon_port;
  logic [31:0] mon_rdata;
  logic        mon_err;
  resp_t       mon_exp;

  always @(negedge clk) begin
    check("one_ready", lsu_ready & fpu_ready, 0);
    if (lsu_ready ^ fpu_ready) begin
      mon_port  = fpu_ready;
      mon_rdata = fpu_ready ? fpu_rdata : lsu_rdata;
      mon_err   = fpu_ready ? fpu_err : lsu_err;
      $display("txn port=%0d rdata=0x%08h err=%0b", mon_port, mon_rdata, mon_err);
      check("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("resp_port", mon_port, mon_exp.port);
        check("resp_rdata", mon_rdata, mon_exp.rdata);
        check("resp_err", mon_err, mon_exp.err);
      end
    end
    if (!lsu_ready) check("lsu_quiet", {lsu_err, lsu_rdata}, 0);
    if (!fpu_ready) check("fpu_quiet", {fpu_err, fpu_rdata}, 0);
  end

  task automatic set_req(input bit p, input bit re, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 1'b0) begin
      lsu_re = re; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata;
    end else begin
      fpu_re = re; fpu_we = we; fpu_addr = addr; fpu_wdata = wdata;
    end
  endtask

  task automatic clr_req(input bit p);
    set_req(p, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e;
    rst = 1'b0;
    clr_req(0);
    clr_req(1);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_ready", {lsu_ready, fpu_ready}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single LSU read, zero wait states
    wait_cycles = 0;
    set_req(0, 1, 0, 32'h100, 32'd0);
    sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    @(negedge clk);
    check("t1_mem_re", mem_re, 1);
    check("t1_mem_we", mem_we, 0);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_grant", grant_id, 0);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_ready", lsu_ready, 1);
    check("t1_rdata", lsu_rdata, 32'hDEADBEEF);
    check("t1_mem_re_off", mem_re, 0);
    clr_req(0);
    @(negedge clk);
    check("t1_idle", busy, 0);

    // FPU write with 3 wait states (ready lands on the timeout cycle)
    wait_cycles = 3;
    set_req(1, 0, 1, 32'h40, 32'h3F800000);
    sb.push_back('{1'b1, 32'd0, 1'b0});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("t2_mem_we", mem_we, 1);
      check("t2_mem_addr", mem_addr, 32'h40);
      check("t2_mem_wdata", mem_wdata, 32'h3F800000);
      check("t2_ready_early", fpu_ready, 0);
    end
    @(negedge clk);
    check("t2_ready", fpu_ready, 1);
    check("t2_err", fpu_err, 0);
    check("t2_rdata", fpu_rdata, 0);
    check("t2_mem_we_off", mem_we, 0);
    clr_req(1);
    @(negedge clk);
    check("t2_pulse", fpu_ready, 0);
    wait_cycles = 0;

    // Stray mem_ready while idle must be ignored
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_idle", busy, 0);
    stray = 1'b0;
    @(negedge clk);

    // Both ports request, held: grants alternate 0,1,0,1
    set_req(0, 1, 0, 32'h500, 32'd0);
    set_req(1, 1, 0, 32'h600, 32'd0);
    for (int i = 0; i < 4; i++) begin
      e = (i % 2 == 1);
      sb.push_back('{e, RD_BASE ^ (e ? 32'h600 : 32'h500), 1'b0});
      @(negedge clk);
      check("t3_grant", grant_id, e);
      check("t3_mem_addr", mem_addr, e ? 32'h600 : 32'h500);
      check("t3_loser_wait", e ? lsu_ready : fpu_ready, 0);
      @(negedge clk);
      check("t3_ready", e ? fpu_ready : lsu_ready, 1);
      check("t3_loser_ready", e ? lsu_ready : fpu_ready, 0);
      if (i == 3) begin
        clr_req(0);
        clr_req(1);
      end
      @(negedge clk);
      check("t3_arb_idle", busy, 0);
    end

    // Timeout: memory never answers
    hang = 1'b1;
    set_req(1, 1, 0, 32'h80, 32'd0);
    sb.push_back('{1'b1, 32'd0, 1'b1});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("t4_mem_re", mem_re, 1);
      check("t4_no_ready", fpu_ready, 0);
    end
    @(negedge clk);
    check("t4_ready", fpu_ready, 1);
    check("t4_err", fpu_err, 1);
    check("t4_rdata", fpu_rdata, 0);
    check("t4_mem_re_off", mem_re, 0);
    clr_req(1);
    hang = 1'b0;
    @(negedge clk);
    check("t4_idle", busy, 0);
    set_req(1, 1, 0, 32'h84, 32'd0);
    sb.push_back('{1'b1, RD_BASE ^ 32'h84, 1'b0});
    @(negedge clk);
    check("t4b_mem_re", mem_re, 1);
    @(negedge clk);
    check("t4b_ready", fpu_ready, 1);
    check("t4b_err", fpu_err, 0);
    clr_req(1);
    @(negedge clk);

    // Illegal request: re and we together
    set_req(0, 1, 1, 32'h200, 32'h1234);
    sb.push_back('{1'b0, 32'd0, 1'b1});
    @(negedge clk);
    check("t5_mem_strobes", {mem_re, mem_we}, 0);
    check("t5_busy", busy, 1);
    @(negedge clk);
    check("t5_ready", lsu_ready, 1);
    check("t5_err", lsu_err, 1);
    check("t5_mem_strobes2", {mem_re, mem_we}, 0);
    clr_req(0);
    @(negedge clk);
    check("t5_idle", busy, 0);

    // Reset in the second ACCESS cycle
    hang = 1'b1;
    set_req(0, 1, 0, 32'h300, 32'd0);
    @(negedge clk);
    check("t6_mem_re", mem_re, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_mem_re", mem_re, 0);
    check("t6_rst_mem_addr", mem_addr, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", {lsu_ready, fpu_ready}, 0);
    clr_req(0);
    hang = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    set_req(0, 1, 0, 32'h700, 32'd0);
    set_req(1, 1, 0, 32'h704, 32'd0);
    sb.push_back('{1'b0, RD_BASE ^ 32'h700, 1'b0});
    @(negedge clk);
    check("t6_tie_grant", grant_id, 0);
    @(negedge clk);
    check("t6_tie_ready", lsu_ready, 1);
    clr_req(0);
    clr_req(1);
    @(negedge clk);
    check("t6_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
